// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter slice.
//   dn_cmd_e : command codes driven on DN_CMD towards the memory model
//   state_e  : transaction FSM states
//   ptr_w()  : index width for an N-entry one-hot vector (at least 1 bit)
package mem_bus_pkg;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_RESP       = 2'b01,  // reserved code, never driven by the arbiter
    CMD_READ_LINE  = 2'b10,
    CMD_WRITE_LINE = 2'b11
  } dn_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WR_BURST,
    ST_WAIT_RESP,
    ST_RD_BURST,
    ST_DONE
  } state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of upstream (cache-side) and downstream (memory-side) signals.
//   master modport : arbiter view (drives grants, read data, memory command)
//   slave  modport : environment view (requesters plus memory model)
// Upstream vectors are packed per port: port i at [i*W +: W].
interface mem_bus_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16
);

  logic [N_PORTS-1:0]        UP_REQ;
  logic [N_PORTS-1:0]        UP_WR;
  logic [N_PORTS*ADDR_W-1:0] UP_ADDR;
  logic [N_PORTS*DATA_W-1:0] UP_WDATA;
  logic [N_PORTS-1:0]        UP_GNT;
  logic [N_PORTS-1:0]        UP_WREADY;
  logic [N_PORTS-1:0]        UP_RVALID;
  logic [DATA_W-1:0]         UP_RDATA;
  logic [N_PORTS-1:0]        UP_DONE;
  logic [N_PORTS-1:0]        UP_ERR;
  logic [1:0]                DN_CMD;
  logic [ADDR_W-1:0]         DN_ADDR;
  logic [DATA_W-1:0]         DN_WDATA;
  logic                      DN_RESP;
  logic [DATA_W-1:0]         DN_RDATA;

  modport master (
    input  UP_REQ, UP_WR, UP_ADDR, UP_WDATA, DN_RESP, DN_RDATA,
    output UP_GNT, UP_WREADY, UP_RVALID, UP_RDATA, UP_DONE, UP_ERR,
           DN_CMD, DN_ADDR, DN_WDATA
  );

  modport slave (
    output UP_REQ, UP_WR, UP_ADDR, UP_WDATA, DN_RESP, DN_RDATA,
    input  UP_GNT, UP_WREADY, UP_RVALID, UP_RDATA, UP_DONE, UP_ERR,
           DN_CMD, DN_ADDR, DN_WDATA
  );

endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational N-way round-robin pick.
//   req        : request vector
//   last_grant : index of the most recently served port
//   gnt        : one-hot winner (all zero when nobody requests)
//   gnt_idx    : binary index of the winner
// Scan starts at last_grant+1 and wraps, so the last winner has lowest priority.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = ptr_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   last_grant,
  output logic [N_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= N_PORTS; off++) begin
      cand = PTR_W'((32'(last_grant) + off) % N_PORTS);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between N cache-side line requesters and one memory bus.
//   CLK   : clock, rising edge
//   RESET : synchronous active-low reset; aborts any transaction without DONE
//   bus   : mem_bus_arbiter_if master modport (UP_* requester side, DN_* memory)
// Grants whole-line READ/WRITE transactions, streams BURST_LEN beats each way,
// and ends a transaction with UP_ERR if memory stays silent for TIMEOUT cycles.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_bus_arbiter_if.master bus
);

  localparam int PTR_W  = ptr_w(N_PORTS);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [N_PORTS-1:0]  gnt_q;
  logic [PTR_W-1:0]    idx_q;
  logic [PTR_W-1:0]    last_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                err_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [N_PORTS-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                beat_last;
  logic                tmo_hit;
  logic [DATA_W-1:0]   sel_wdata;

  dn_cmd_e             dn_cmd;
  logic [ADDR_W-1:0]   dn_addr;
  logic [DATA_W-1:0]   dn_wdata;
  logic [N_PORTS-1:0]  wready;
  logic [N_PORTS-1:0]  done;
  logic [N_PORTS-1:0]  err;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req        (bus.UP_REQ),
    .last_grant (last_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign beat_last = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT));
  assign sel_wdata = bus.UP_WDATA[idx_q*DATA_W +: DATA_W];

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dn_cmd   = CMD_NOP;
    dn_addr  = '0;
    dn_wdata = '0;
    wready   = '0;
    done     = '0;
    err      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.UP_REQ) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        dn_cmd  = wr_q ? CMD_WRITE_LINE : CMD_READ_LINE;
        dn_addr = addr_q;
        if (wr_q) begin
          dn_wdata = sel_wdata;
          wready   = gnt_q;
          state_d  = ST_WR_BURST;
        end else begin
          state_d  = ST_WAIT_RESP;
        end
      end
      ST_WR_BURST: begin
        dn_cmd   = CMD_WRITE_LINE;
        dn_addr  = addr_q;
        dn_wdata = sel_wdata;
        wready   = gnt_q;
        if (beat_last) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (bus.DN_RESP) state_d = wr_q ? ST_DONE : ST_RD_BURST;
        else if (tmo_hit) state_d = ST_DONE;
      end
      ST_RD_BURST: begin
        if (bus.DN_RESP) begin
          if (beat_last) state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = gnt_q;
        err     = err_q ? gnt_q : '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timeout counter restarts on every accepted beat, so in RD_BURST it measures
  // the gap since the previous beat; it stops at TIMEOUT because the FSM leaves.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      gnt_q    <= '0;
      idx_q    <= '0;
      last_q   <= PTR_W'(N_PORTS - 1);
      wr_q     <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.UP_REQ) begin
            gnt_q  <= arb_gnt;
            idx_q  <= arb_idx;
            wr_q   <= bus.UP_WR[arb_idx];
            addr_q <= bus.UP_ADDR[arb_idx*ADDR_W +: ADDR_W];
            err_q  <= 1'b0;
            beat_q <= '0;
          end
        end
        ST_ISSUE: begin
          tmo_q <= '0;
          if (wr_q) beat_q <= BEAT_W'(1);
        end
        ST_WR_BURST: begin
          tmo_q  <= '0;
          beat_q <= beat_last ? '0 : beat_q + 1'b1;
        end
        ST_WAIT_RESP: begin
          if (bus.DN_RESP) begin
            tmo_q <= '0;
            if (!wr_q) begin
              rvalid_q <= 1'b1;
              rdata_q  <= bus.DN_RDATA;
              beat_q   <= BEAT_W'(1);
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RD_BURST: begin
          if (bus.DN_RESP) begin
            rvalid_q <= 1'b1;
            rdata_q  <= bus.DN_RDATA;
            tmo_q    <= '0;
            beat_q   <= beat_last ? '0 : beat_q + 1'b1;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          last_q <= idx_q;
          gnt_q  <= '0;
          err_q  <= 1'b0;
          beat_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.UP_GNT    = gnt_q;
  assign bus.UP_WREADY = wready;
  assign bus.UP_RVALID = rvalid_q ? gnt_q : '0;
  assign bus.UP_RDATA  = rdata_q;
  assign bus.UP_DONE   = done;
  assign bus.UP_ERR    = err;
  assign bus.DN_CMD    = dn_cmd;
  assign bus.DN_ADDR   = dn_addr;
  assign bus.DN_WDATA  = dn_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (4 ports, 8-beat bursts, TIMEOUT=10).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_bus_arbiter;

  localparam int NP = 4;
  localparam int AW = 14;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  mem_bus_arbiter_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bif ();

  mem_bus_arbiter #(
    .N_PORTS   (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_LEN (8),
    .TIMEOUT   (10)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bif.UP_REQ   = '0;
    bif.UP_WR    = '0;
    bif.UP_ADDR  = '0;
    bif.UP_WDATA = '0;
    bif.DN_RESP  = 1'b0;
    bif.DN_RDATA = '0;
  endtask

  // Called on a falling edge; returns on a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          cnt;
  int          ngr;
  int          viol;
  int          wbeat;
  logic        prev_wr;
  logic [3:0]  gseq [5];
  logic [3:0]  exp_v;
  logic [15:0] wexp;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    check_eq("rst_gnt",    32'(bif.UP_GNT), 0);
    check_eq("rst_cmd",    32'(bif.DN_CMD), 0);
    check_eq("rst_rvalid", 32'(bif.UP_RVALID), 0);
    check_eq("rst_done",   32'(bif.UP_DONE), 0);

    // Test 1: port 0 read, memory answers 5 cycles after ISSUE
    bif.UP_REQ = 4'b0001;
    bif.UP_ADDR[0 +: AW] = 14'h0123;
    @(negedge clk); #1;
    check_eq("t1_gnt",  32'(bif.UP_GNT), 32'h1);
    check_eq("t1_cmd0", 32'(bif.DN_CMD), 32'h2);
    check_eq("t1_addr", 32'(bif.DN_ADDR), 32'h0123);
    cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bif.DN_RESP  = (k >= 5 && k <= 12);
      bif.DN_RDATA = 16'(32'hA000 + k - 5);
      #1;
      check_eq("t1_cmd", 32'(bif.DN_CMD), 0);
      exp_v = (k >= 6 && k <= 13) ? 4'b0001 : 4'b0000;
      check_eq("t1_rvalid", 32'(bif.UP_RVALID), 32'(exp_v));
      if (exp_v != 0) check_eq("t1_rdata", 32'(bif.UP_RDATA), 32'hA000 + 32'(k - 6));
      check_eq("t1_done", 32'(bif.UP_DONE), (k == 13) ? 32'h1 : 32'h0);
      check_eq("t1_err",  32'(bif.UP_ERR), 0);
      if (bif.UP_RVALID[0]) cnt++;
    end
    check_eq("t1_nbeats", 32'(cnt), 8);
    bif.UP_REQ  = '0;
    bif.DN_RESP = 1'b0;

    // Test 2: port 1 write, data 0x1111..0x8888, ack in WAIT_RESP
    @(negedge clk);
    bif.UP_REQ = 4'b0010;
    bif.UP_WR  = 4'b0010;
    bif.UP_ADDR[AW +: AW] = 14'h02AB;
    wbeat   = 0;
    prev_wr = 1'b0;
    cnt     = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (prev_wr) wbeat++;
      bif.UP_WDATA[DW +: DW] = 16'(32'h1111 * (wbeat + 1));
      bif.DN_RESP = (k == 8);
      #1;
      if (k == 0) check_eq("t2_gnt", 32'(bif.UP_GNT), 32'h2);
      wexp = 16'(32'h1111 * (k + 1));
      check_eq("t2_wready", 32'(bif.UP_WREADY), (k <= 7) ? 32'h2 : 32'h0);
      check_eq("t2_cmd",    32'(bif.DN_CMD), (k <= 7) ? 32'h3 : 32'h0);
      check_eq("t2_wdata",  32'(bif.DN_WDATA), (k <= 7) ? 32'(wexp) : 32'h0);
      check_eq("t2_done",   32'(bif.UP_DONE), (k == 9) ? 32'h2 : 32'h0);
      prev_wr = bif.UP_WREADY[1];
      if (bif.UP_WREADY[1]) cnt++;
    end
    check_eq("t2_nready", 32'(cnt), 8);
    bif.UP_REQ  = '0;
    bif.UP_WR   = '0;
    bif.DN_RESP = 1'b0;

    // Test 3: all four ports write continuously, memory acks at once
    @(negedge clk);
    do_reset();
    bif.UP_REQ  = 4'b1111;
    bif.UP_WR   = 4'b1111;
    bif.DN_RESP = 1'b1;
    ngr  = 0;
    viol = 0;
    for (int i = 0; i < 5; i++) gseq[i] = 4'hF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); #1;
      if ((bif.UP_GNT & (bif.UP_GNT - 4'd1)) != 4'd0) viol++;
      if (bif.UP_DONE != 0 && ngr < 5) begin
        for (int p = 0; p < NP; p++)
          if (bif.UP_DONE[p]) gseq[ngr] = 4'(p);
        ngr++;
      end
    end
    check_eq("t3_onehot", 32'(viol), 0);
    check_eq("t3_g0", 32'(gseq[0]), 0);
    check_eq("t3_g1", 32'(gseq[1]), 1);
    check_eq("t3_g2", 32'(gseq[2]), 2);
    check_eq("t3_g3", 32'(gseq[3]), 3);
    check_eq("t3_g4", 32'(gseq[4]), 0);

    // Test 4: port 2 read with silent memory, then a normal port 1 write
    do_reset();
    bif.UP_REQ = 4'b0100;
    bif.UP_ADDR[2*AW +: AW] = 14'h0055;
    @(negedge clk); #1;
    check_eq("t4_gnt", 32'(bif.UP_GNT), 32'h4);
    check_eq("t4_cmd", 32'(bif.DN_CMD), 32'h2);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      check_eq("t4_done",   32'(bif.UP_DONE), (k == 12) ? 32'h4 : 32'h0);
      check_eq("t4_err",    32'(bif.UP_ERR),  (k == 12) ? 32'h4 : 32'h0);
      check_eq("t4_rvalid", 32'(bif.UP_RVALID), 0);
    end
    bif.UP_REQ = '0;
    @(negedge clk);
    bif.UP_REQ  = 4'b0010;
    bif.UP_WR   = 4'b0010;
    bif.DN_RESP = 1'b1;
    @(negedge clk); #1;
    check_eq("t4b_gnt", 32'(bif.UP_GNT), 32'h2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1;
      check_eq("t4b_done", 32'(bif.UP_DONE), (k == 9) ? 32'h2 : 32'h0);
      check_eq("t4b_err",  32'(bif.UP_ERR), 0);
    end
    bif.UP_REQ  = '0;
    bif.UP_WR   = '0;
    bif.DN_RESP = 1'b0;

    // Test 5: reset after read beat 3; last grant was port 1
    @(negedge clk);
    bif.UP_REQ = 4'b0001;
    bif.UP_ADDR[0 +: AW] = 14'h03FF;
    @(negedge clk); #1;
    check_eq("t5_gnt", 32'(bif.UP_GNT), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bif.DN_RESP  = 1'b1;
      bif.DN_RDATA = 16'(32'hB000 + k - 1);
    end
    @(negedge clk);
    bif.DN_RESP = 1'b0;
    #1;
    check_eq("t5_rvalid3", 32'(bif.UP_RVALID), 32'h1);
    check_eq("t5_rdata3",  32'(bif.UP_RDATA), 32'hB003);
    rst_n = 1'b0;
    bif.UP_REQ = '0;
    @(negedge clk); #1;
    check_eq("t5_gnt_rst",    32'(bif.UP_GNT), 0);
    check_eq("t5_rvalid_rst", 32'(bif.UP_RVALID), 0);
    check_eq("t5_rdata_rst",  32'(bif.UP_RDATA), 0);
    check_eq("t5_done_rst",   32'(bif.UP_DONE), 0);
    check_eq("t5_cmd_rst",    32'(bif.DN_CMD), 0);
    rst_n = 1'b1;
    bif.UP_REQ = 4'b1001;
    bif.UP_WR  = 4'b1001;
    @(negedge clk); #1;
    check_eq("t5_gnt_after", 32'(bif.UP_GNT), 32'h1);
    check_eq("t5_cmd_after", 32'(bif.DN_CMD), 32'h3);

    // Test 6: read beats separated by two idle cycles
    do_reset();
    bif.UP_REQ = 4'b0001;
    bif.UP_ADDR[0 +: AW] = 14'h01A5;
    @(negedge clk); #1;
    check_eq("t6_gnt", 32'(bif.UP_GNT), 32'h1);
    cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bif.DN_RESP  = (k >= 1 && (k - 1) % 3 == 0 && (k - 1) / 3 < 8);
      bif.DN_RDATA = 16'(32'hC000 + (k - 1) / 3);
      #1;
      exp_v = (k >= 2 && (k - 2) % 3 == 0 && (k - 2) / 3 < 8) ? 4'b0001 : 4'b0000;
      check_eq("t6_rvalid", 32'(bif.UP_RVALID), 32'(exp_v));
      if (exp_v != 0) check_eq("t6_rdata", 32'(bif.UP_RDATA), 32'hC000 + 32'((k - 2) / 3));
      check_eq("t6_done", 32'(bif.UP_DONE), (k == 23) ? 32'h1 : 32'h0);
      check_eq("t6_err",  32'(bif.UP_ERR), 0);
      if (bif.UP_RVALID[0]) cnt++;
      if (k == 23) bif.UP_REQ = '0;
    end
    check_eq("t6_nbeats", 32'(cnt), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
